multi_trip_cycle_counter: RTL and testbench

- Parametrised successor to the two-channel trip timer in the capstone acceleration datapath.
- Measures the clock cycles from a start event to the first assertion of each of NUM_CH trip inputs.
- Adds per-channel enables, a trip mask, timeout with saturation, and restart without reset.
- Results feed the host readout / calculation modules.

---
 rtl/multi_trip_cycle_counter.sv | 157 +++++++++++++++
 tb/tb_multi_trip_cycle_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_trip_cycle_counter.sv
// multi_trip_cycle_counter
// Counts clock cycles from a start event (falling edge of startSequence) to
// the first sampled-high level on each of NUM_CH trip inputs. Each channel can
// be enabled per run. A run finishes when every enabled channel has latched a
// count, or when the cycle counter reaches its limit (timeout).
//
// Build option: define TRIP_SYNC_EN to pass every tripped bit through a
// 2-flop synchroniser before it is qualified (for inputs asynchronous to CLK).
//
// Handshake: there is no valid/ready pair. A run is requested by a high-then-
// low pulse on startSequence. busy is high while counting. hasTripped marks
// that the results are valid, and they stay valid until the next start or reset.
module multi_trip_cycle_counter #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    startSequence,
    input  logic [NUM_CH-1:0]       tripped,
    input  logic [NUM_CH-1:0]       chEnable,
    output logic                    hasTripped,
    output logic                    timedOut,
    output logic                    busy,
    output logic [NUM_CH-1:0]       tripMask,
    output logic [NUM_CH*CNT_W-1:0] theCounts
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNTING = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    // Counter value that aborts a run; zero selects the saturation value so the
    // counter can never wrap.
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}}
                                                               : CNT_W'(TIMEOUT_CYCLES);

    state_t                    state_q;
    logic [CNT_W-1:0]          counter_q;
    logic                      start_q;
    logic [NUM_CH-1:0]         en_q;
    logic [NUM_CH-1:0]         mask_q;
    logic [NUM_CH*CNT_W-1:0]   counts_q;
    logic                      has_tripped_q;
    logic                      timed_out_q;
    logic                      busy_q;

    logic [NUM_CH-1:0]         trip_s;
    logic                      start_fall;
    logic [NUM_CH-1:0]         start_hit;
    logic [NUM_CH-1:0]         run_hit;
    logic                      all_done;
    logic                      at_limit;

`ifdef TRIP_SYNC_EN
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // Two-flop synchroniser on every trip input.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= tripped;
            sync2_q <= sync1_q;
        end
    end

    assign trip_s = sync2_q;
`else
    assign trip_s = tripped;
`endif

    // Start edge detection and per-channel trip qualification.
    always_comb begin
        start_fall = start_q & ~startSequence;
        start_hit  = chEnable & trip_s;
        run_hit    = en_q & trip_s & ~mask_q;
        all_done   = ((mask_q & en_q) == en_q);
        at_limit   = (counter_q == LIMIT);
    end

    // Run control FSM with counter, latched results and registered flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            counter_q     <= '0;
            start_q       <= 1'b0;
            en_q          <= '0;
            mask_q        <= '0;
            counts_q      <= '0;
            has_tripped_q <= 1'b0;
            timed_out_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            start_q <= startSequence;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_fall) begin
                        state_q       <= S_COUNTING;
                        busy_q        <= 1'b1;
                        counter_q     <= '0;
                        en_q          <= chEnable;
                        // A trip already high at the start edge counts as 0,
                        // which is also the cleared value of its result.
                        mask_q        <= start_hit;
                        counts_q      <= '0;
                        has_tripped_q <= 1'b0;
                        timed_out_q   <= 1'b0;
                    end
                end
                S_COUNTING: begin
                    if (all_done) begin
                        // Completion is registered one edge after the last latch.
                        state_q       <= S_DONE;
                        busy_q        <= 1'b0;
                        has_tripped_q <= 1'b1;
                    end else begin
                        mask_q <= mask_q | run_hit;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (run_hit[i]) begin
                                counts_q[i*CNT_W +: CNT_W] <= counter_q;
                            end else if (at_limit && en_q[i] && !mask_q[i]) begin
                                counts_q[i*CNT_W +: CNT_W] <= {CNT_W{1'b1}};
                            end
                        end
                        if (at_limit) begin
                            // Channels still outstanding at the limit: abort
                            // without incrementing so the counter never wraps.
                            state_q       <= S_DONE;
                            busy_q        <= 1'b0;
                            has_tripped_q <= 1'b1;
                            timed_out_q   <= 1'b1;
                        end else begin
                            counter_q <= counter_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hasTripped = has_tripped_q;
    assign timedOut   = timed_out_q;
    assign busy       = busy_q;
    assign tripMask   = mask_q;
    assign theCounts  = counts_q;

endmodule

// File: tb/tb_multi_trip_cycle_counter.sv
// Bench for multi_trip_cycle_counter with NUM_CH=2, CNT_W=32.
// Two instances share all inputs: dut_a without timeout (limit is saturation)
// and dut_b with TIMEOUT_CYCLES=100; each row selects which one it checks.
// "Cycle N" of a run means the edge at which the counter holds N, i.e. the
// (N+1)-th edge after the start edge; a trip there latches count N.
module tb_multi_trip_cycle_counter;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 32;
    localparam int TO_LIM   = 100;
    localparam int AT_START = -1;
    localparam int NEVER    = -2;
    localparam int BUDGET   = 30000;
    localparam int N_ROWS   = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start_seq = 1'b0;
    logic [NUM_CH-1:0] tripped   = '0;
    logic [NUM_CH-1:0] ch_en     = '0;

    logic                    has_a, to_a, busy_a, has_b, to_b, busy_b;
    logic [NUM_CH-1:0]       mask_a, mask_b;
    logic [NUM_CH*CNT_W-1:0] cnt_a, cnt_b;

    multi_trip_cycle_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(0)) dut_a (
        .CLK(clk), .RST(rst_n), .startSequence(start_seq), .tripped(tripped),
        .chEnable(ch_en), .hasTripped(has_a), .timedOut(to_a), .busy(busy_a),
        .tripMask(mask_a), .theCounts(cnt_a)
    );

    multi_trip_cycle_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_LIM)) dut_b (
        .CLK(clk), .RST(rst_n), .startSequence(start_seq), .tripped(tripped),
        .chEnable(ch_en), .hasTripped(has_b), .timedOut(to_b), .busy(busy_b),
        .tripMask(mask_b), .theCounts(cnt_b)
    );

    logic                    sel_to = 1'b0;
    logic                    has_s, to_s, busy_s;
    logic [NUM_CH-1:0]       mask_s;
    logic [NUM_CH*CNT_W-1:0] cnt_s;
    assign has_s  = sel_to ? has_b  : has_a;
    assign to_s   = sel_to ? to_b   : to_a;
    assign busy_s = sel_to ? busy_b : busy_a;
    assign mask_s = sel_to ? mask_b : mask_a;
    assign cnt_s  = sel_to ? cnt_b  : cnt_a;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [66:0] exp_q[$];

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  en;
        int          cyc0;
        int          cyc1;
        bit          use_to;
        int          ghost;     // edge offset of an extra start pulse, 0 = none
        logic [66:0] exp_res;   // {timedOut, tripMask, count1, count0}
        int          exp_done;  // edge offset (from start edge) where hasTripped is seen
    } row_t;

    // Reference model: expected results from the trip schedule.
    function automatic row_t mk_row(input logic [1:0] en, input int c0, input int c1,
                                    input bit use_to, input int ghost);
        row_t r;
        logic [31:0] cnt [2];
        logic [1:0]  m;
        bit          outstanding;
        int          last;
        int          cyc;
        m = '0; outstanding = 0; last = 0;
        for (int ch = 0; ch < 2; ch++) begin
            cyc = (ch == 0) ? c0 : c1;
            cnt[ch] = '0;
            if (en[ch]) begin
                if (cyc == NEVER) begin
                    outstanding = 1;
                    cnt[ch] = 32'hFFFF_FFFF;
                end else begin
                    m[ch] = 1'b1;
                    cnt[ch] = (cyc == AT_START) ? 32'd0 : 32'(cyc);
                    if (cyc != AT_START && cyc + 1 > last) last = cyc + 1;
                end
            end
        end
        r.en = en; r.cyc0 = c0; r.cyc1 = c1; r.use_to = use_to; r.ghost = ghost;
        r.exp_res  = {outstanding, m, cnt[1], cnt[0]};
        r.exp_done = outstanding ? TO_LIM + 1 : last + 1;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start_seq = 1'b0; tripped = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int edge_of(input logic en_bit, input int cyc);
        if (!en_bit) return -1;
        if (cyc == AT_START) return 0;
        if (cyc == NEVER) return 1 << 30;
        return cyc + 1;
    endfunction

    // Drive trip levels for the edge at offset k: low before the trip edge,
    // high at it, random afterwards; disabled channels are random throughout.
    task automatic drive_trips(input int off0, input int off1, input int k);
        int off;
        for (int ch = 0; ch < 2; ch++) begin
            off = (ch == 0) ? off0 : off1;
            if (off < 0 || k > off) tripped[ch] = 1'($urandom_range(0, 1));
            else tripped[ch] = (k == off);
        end
    endtask

    task automatic run_row(input row_t r, input bit with_reset, input string tag);
        int off0, off1, done_at;
        logic [1:0] m_exp;
        logic [66:0] e;
        if (with_reset) do_reset();
        sel_to = r.use_to;
        off0 = edge_of(r.en[0], r.cyc0);
        off1 = edge_of(r.en[1], r.cyc1);
        @(negedge clk);
        ch_en = r.en;
        start_seq = 1'b1;
        tripped = '0;
        @(negedge clk);
        start_seq = 1'b0;
        drive_trips(off0, off1, 0);
        exp_q.push_back(r.exp_res);
        done_at = -1;
        for (int k = 0; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ch_en = 2'($urandom_range(0, 3));  // enables were latched at the start edge
                check({tag, " cleared"}, {busy_s, to_s, cnt_s}, {1'b1, 1'b0, 64'd0});
            end
            if (has_s) begin
                done_at = k;
                break;
            end
            m_exp = '0;
            if (off0 >= 0 && off0 <= k) m_exp[0] = 1'b1;
            if (off1 >= 0 && off1 <= k) m_exp[1] = 1'b1;
            if (k == 0 || k + 1 == off0 || k + 1 == off1 || k == off0 || k == off1)
                check({tag, " mask"}, 67'(mask_s), 67'(m_exp));
            drive_trips(off0, off1, k + 1);
            start_seq = (r.ghost > 0 && k + 1 == r.ghost);
        end
        start_seq = 1'b0;
        check({tag, " done_edge"}, 67'(done_at), 67'(r.exp_done));
        e = exp_q.pop_front();
        check({tag, " result"}, {to_s, mask_s, cnt_s}, e);
        check({tag, " busy_done"}, 67'(busy_s), 67'd0);
        repeat (3) @(negedge clk);
        check({tag, " hold"}, {has_s, to_s, mask_s, cnt_s}, {1'b1, e});
    endtask

    // ---------------- test ----------------
    row_t rows [N_ROWS];

    initial begin
        rows[0]  = mk_row(2'b11, AT_START, 25000, 0, 0);
        rows[1]  = mk_row(2'b11, 10, 7, 0, 0);
        rows[2]  = mk_row(2'b01, 40, 0, 0, 0);
        rows[3]  = mk_row(2'b11, 30, NEVER, 1, 0);
        rows[4]  = mk_row(2'b00, 0, 0, 0, 0);
        rows[5]  = mk_row(2'b11, AT_START, AT_START, 0, 0);
        rows[6]  = mk_row(2'b10, 0, 0, 0, 0);
        rows[7]  = mk_row(2'b11, 5, 99, 1, 0);
        rows[8]  = mk_row(2'b10, 0, NEVER, 1, 0);
        for (int i = 9; i < N_ROWS; i++)
            rows[i] = mk_row(2'($urandom_range(1, 3)), int'($urandom_range(0, 60)),
                             int'($urandom_range(0, 60)), 0, 0);

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        check("reset_a", {has_a, to_a, busy_a, mask_a, cnt_a}, 67'd0);
        check("reset_b", {has_b, to_b, busy_b, mask_b, cnt_b}, 67'd0);
        rst_n = 1'b1;

        for (int i = 0; i < N_ROWS; i++) run_row(rows[i], 1'b1, $sformatf("row%0d", i));

        // Start pulse during COUNTING is ignored, then a restart from DONE.
        run_row(mk_row(2'b11, 20, 30, 0, 5), 1'b1, "ghost_start");
        run_row(mk_row(2'b11, 5, 6, 0, 0), 1'b0, "restart");

        // Asynchronous reset in the middle of a run.
        do_reset();
        sel_to = 1'b0;
        ch_en = 2'b11;
        start_seq = 1'b1;
        @(negedge clk);
        start_seq = 1'b0;
        tripped = 2'b00;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            tripped = (k >= 11) ? 2'b01 : 2'b00;
        end
        check("mid_run_busy", {busy_a, mask_a}, {1'b1, 2'b01});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {has_a, to_a, busy_a, mask_a, cnt_a}, 67'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tripped = '0;
        run_row(mk_row(2'b11, 3, 4, 0, 0), 1'b0, "after_reset");

        check("queue_empty", 67'(exp_q.size()), 67'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
